counter_arbiter: RTL and testbench

- Shares one WIDTH-bit up/down/load counter register between REQUESTERS independent requesters (e.g. mouse, reset logic, host).
- Updates only on a prescaled slot strobe, replacing the ad-hoc half-clock scheme with a single-clock enable.
- Round-robin arbitration: at most one operation is applied per slot, and the winner gets a one-cycle ack.
- Sits between requester logic and the value consumer (display/output port).

---
 rtl/counter_arbiter_if.sv | 18 +
 rtl/counter_arbiter.sv | 120 ++++++++++++
 tb/tb_counter_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: requester-side bus for the shared counter.
// Per-requester fields are packed as [REQUESTERS-1:0][...], so requester i
// occupies op[2i+1:2i] and data[WIDTH*i+WIDTH-1:WIDTH*i] when flattened.
interface counter_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int REQUESTERS = 4
);
  logic [REQUESTERS-1:0]            req;
  logic [REQUESTERS-1:0][1:0]       op;
  logic [REQUESTERS-1:0][WIDTH-1:0] data;
  logic [REQUESTERS-1:0]            ack;
  logic [WIDTH-1:0]                 value;
  logic                             slot;
  logic                             limit;

  modport master (output req, op, data, input ack, value, slot, limit);
  modport slave  (input req, op, data, output ack, value, slot, limit);
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter: one WIDTH-bit up/down/load/clear counter shared by
// REQUESTERS requesters. A prescaler opens an update slot every DIVIDE
// clocks; in a slot a round-robin arbiter picks at most one requester, whose
// op is applied and acked one clock later together with the new value.
// Build option: SATURATE_EN -- inc at max / dec at zero hold the value
// instead of wrapping; limit pulses in both builds.
module counter_arbiter #(
  parameter int WIDTH      = 16,
  parameter int REQUESTERS = 4,
  parameter int DIVIDE     = 2
) (
  input logic               clock,
  input logic               reset_,
  counter_arbiter_if.slave  bus
);
  localparam int PW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int IW = $clog2(REQUESTERS);

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         ptr;
  logic [WIDTH-1:0]      value_q;
  logic [REQUESTERS-1:0] ack_q;
  logic                  limit_q;

  logic                  slot;
  logic                  found;
  logic [IW-1:0]         win;
  logic [IW-1:0]         cand;
  logic [1:0]            sel_op;
  logic [WIDTH-1:0]      sel_data;
  logic [WIDTH-1:0]      nxt_val;
  logic                  nxt_lim;
  logic                  fire;

  // With DIVIDE=1 the prescaler never leaves 0, so slot is constantly high.
  assign slot = (presc == PW'(DIVIDE - 1));
  assign fire = slot && found;

  // Prescaler: counts 0..DIVIDE-1 and wraps on the slot cycle.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_)   presc <= '0;
    else if (slot) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Round-robin search: first requester at or after ptr, wrapping upward.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand = IW'((int'(ptr) + k) % REQUESTERS);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign sel_op   = bus.op[win];
  assign sel_data = bus.data[win];

  // Winner's operation on the current value, plus the limit condition.
  always_comb begin
    nxt_val = value_q;
    nxt_lim = 1'b0;
    case (op_e'(sel_op))
      OP_INC: begin
        nxt_lim = &value_q;
`ifdef SATURATE_EN
        nxt_val = (&value_q) ? value_q : value_q + WIDTH'(1);
`else
        nxt_val = value_q + WIDTH'(1);
`endif
      end
      OP_DEC: begin
        nxt_lim = ~|value_q;
`ifdef SATURATE_EN
        nxt_val = (~|value_q) ? value_q : value_q - WIDTH'(1);
`else
        nxt_val = value_q - WIDTH'(1);
`endif
      end
      OP_LOAD: nxt_val = sel_data;
      OP_CLR:  nxt_val = '0;
      default: nxt_val = value_q;
    endcase
  end

  // Commit the winner: new value, one-hot ack pulse, pointer past the winner.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      value_q <= '0;
      ack_q   <= '0;
      limit_q <= 1'b0;
      ptr     <= '0;
    end else begin
      ack_q   <= '0;
      limit_q <= 1'b0;
      if (fire) begin
        value_q <= nxt_val;
        ack_q   <= REQUESTERS'(1) << win;
        limit_q <= nxt_lim;
        ptr     <= (win == IW'(REQUESTERS - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.value = value_q;
  assign bus.slot  = slot;
  assign bus.limit = limit_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: table of single-requester operations plus hand-written
// sequences for continuous service, withdrawal, round-robin order and an
// asynchronous reset between edges. Expected results go into a scoreboard
// queue when a request is raised and are compared when the ack appears.
module tb_counter_arbiter;
  localparam int W = 16;
  localparam int R = 4;
  localparam int D = 2;

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [W-1:0] data;
    logic [W-1:0] exp_val;
    logic       exp_lim;
  } vec_t;

  typedef struct {
    logic [R-1:0] ack;
    logic [W-1:0] val;
    logic         lim;
  } exp_t;

  logic clock  = 1'b0;
  logic reset_ = 1'b0;
  always #5 clock = ~clock;

  counter_arbiter_if #(.WIDTH(W), .REQUESTERS(R)) bus ();
  counter_arbiter #(.WIDTH(W), .REQUESTERS(R), .DIVIDE(D)) dut (
    .clock (clock),
    .reset_(reset_),
    .bus   (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic [W-1:0] v, input logic l);
    exp_t e;
    e.ack      = '0;
    e.ack[idx] = 1'b1;
    e.val      = v;
    e.lim      = l;
    sb.push_back(e);
  endtask

  // Wait for the next ack, compare it against the oldest expectation and drop
  // the served request.
  task automatic wait_ack(input string name, input int budget);
    exp_t e;
    int   n;
    bit   got;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      tick();
      n++;
      if (bus.ack != '0) got = 1'b1;
    end
    e = sb.pop_front();
    if (got) begin
      check({name, "_ack"},   32'(bus.ack),   32'(e.ack));
      check({name, "_value"}, 32'(bus.value), 32'(e.val));
      check({name, "_limit"}, 32'(bus.limit), 32'(e.lim));
      bus.req = bus.req & ~bus.ack;
    end else begin
      check({name, "_timeout"}, 32'(0), 32'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
`ifdef SATURATE_EN
    vecs[0] = '{2, 2'b10, 16'h1234, 16'h1234, 1'b0};
    vecs[1] = '{1, 2'b10, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[2] = '{1, 2'b00, 16'hxxxx, 16'hFFFF, 1'b1};
    vecs[3] = '{3, 2'b11, 16'hxxxx, 16'h0000, 1'b0};
    vecs[4] = '{0, 2'b01, 16'hxxxx, 16'h0000, 1'b1};
    vecs[5] = '{0, 2'b01, 16'hxxxx, 16'h0000, 1'b1};
    vecs[6] = '{3, 2'b00, 16'hxxxx, 16'h0001, 1'b0};
    vecs[7] = '{1, 2'b10, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[8] = '{0, 2'b11, 16'hxxxx, 16'h0000, 1'b0};
`else
    vecs[0] = '{2, 2'b10, 16'h1234, 16'h1234, 1'b0};
    vecs[1] = '{1, 2'b10, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[2] = '{1, 2'b00, 16'hxxxx, 16'h0000, 1'b1};
    vecs[3] = '{3, 2'b11, 16'hxxxx, 16'h0000, 1'b0};
    vecs[4] = '{0, 2'b01, 16'hxxxx, 16'hFFFF, 1'b1};
    vecs[5] = '{0, 2'b01, 16'hxxxx, 16'hFFFE, 1'b0};
    vecs[6] = '{3, 2'b00, 16'hxxxx, 16'hFFFF, 1'b0};
    vecs[7] = '{1, 2'b10, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[8] = '{0, 2'b11, 16'hxxxx, 16'h0000, 1'b0};
`endif

    // Reset with req[0] inc held throughout; release between edges.
    bus.req  = '0;
    bus.op   = 'x;
    bus.data = 'x;
    bus.req[0] = 1'b1;
    bus.op[0]  = 2'b00;
    repeat (2) @(posedge clock);
    #2;
    check("rst_value", 32'(bus.value), 32'(0));
    check("rst_ack",   32'(bus.ack),   32'(0));
    check("rst_limit", 32'(bus.limit), 32'(0));
    check("rst_slot",  32'(bus.slot),  32'(0));
    #2 reset_ = 1'b1;

    // Continuous inc: slot every 2nd clock, ack[0] and value+1 one clock later.
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e % 2 == 1) begin
        check("cont_slot",  32'(bus.slot),  32'(1));
        check("cont_ack",   32'(bus.ack),   32'(0));
        check("cont_value", 32'(bus.value), 32'((e - 1) / 2));
      end else begin
        check("cont_slot",  32'(bus.slot),  32'(0));
        check("cont_ack",   32'(bus.ack),   32'(1));
        check("cont_value", 32'(bus.value), 32'(e / 2));
      end
      check("cont_limit", 32'(bus.limit), 32'(0));
    end
    bus.req[0] = 1'b0;

    // Table: one requester at a time, other lanes' op/data left unknown.
    for (int i = 0; i < 9; i++) begin
      bus.op   = 'x;
      bus.data = 'x;
      bus.op[vecs[i].idx]   = vecs[i].op;
      bus.data[vecs[i].idx] = vecs[i].data;
      bus.req[vecs[i].idx]  = 1'b1;
      push_exp(vecs[i].idx, vecs[i].exp_val, vecs[i].exp_lim);
      wait_ack($sformatf("vec%0d", i), 20);
      tick();
      check($sformatf("vec%0d_no_reack", i), 32'(bus.ack), 32'(0));
    end

    // Withdrawal: req[1] raised in a non-slot cycle, dropped before the slot.
    for (int n = 0; n < 4 && bus.slot; n++) tick();
    check("wd_nonslot", 32'(bus.slot), 32'(0));
    bus.op[1]  = 2'b00;
    bus.req[1] = 1'b1;
    #3 bus.req[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("wd_ack",   32'(bus.ack),   32'(0));
      check("wd_value", 32'(bus.value), 32'(0));
    end

    // Round robin from pointer 0: all four inc, each dropped on its own ack.
    #2 reset_ = 1'b0;
    #2 reset_ = 1'b1;
    bus.op   = '0;
    bus.data = 'x;
    bus.req  = 4'b1111;
    for (int i = 0; i < 4; i++) push_exp(i, W'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) wait_ack($sformatf("rr%0d", i), 20);
    bus.req[3] = 1'b1;
    push_exp(3, 16'd5, 1'b0);
    wait_ack("rr_lone3", 20);
    bus.req[1] = 1'b1;
    bus.req[3] = 1'b1;
    push_exp(1, 16'd6, 1'b0);
    push_exp(3, 16'd7, 1'b0);
    wait_ack("rr_pair1", 20);
    wait_ack("rr_pair3", 20);

    // Asynchronous reset between edges while ack is high and req[0] pending.
    bus.req[0] = 1'b1;
    push_exp(0, 16'd8, 1'b0);
    wait_ack("ar_pre", 20);
    bus.req[0] = 1'b1;
    #2 reset_ = 1'b0;
    #1;
    check("ar_ack",   32'(bus.ack),   32'(0));
    check("ar_value", 32'(bus.value), 32'(0));
    check("ar_limit", 32'(bus.limit), 32'(0));
    #1 reset_ = 1'b1;
    tick();
    check("ar_e1_slot", 32'(bus.slot),  32'(1));
    check("ar_e1_ack",  32'(bus.ack),   32'(0));
    check("ar_e1_val",  32'(bus.value), 32'(0));
    tick();
    check("ar_e2_ack",  32'(bus.ack),   32'(1));
    check("ar_e2_val",  32'(bus.value), 32'(1));
    bus.req = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
